mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the IF stage (instruction fetch, read-only) and the MM stage (loads/stores).
- Sequences each access: it issues the command, counts the memory latency, captures the read data and returns a one-cycle ready pulse.
- Drives per-stage stall signals into the pipeline hazard logic.
- MM has fixed priority over IF, because MM holds the older instruction.

Parameters:
- MEM_LATENCY, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until the if_ready cycle
- if_addr  in  32  fetch address (word aligned)
- if_flush  in  1  discard the in-flight or pending fetch (branch/jr taken)
- if_rdata  out  32  fetched instruction; held stable until the next IF capture
- if_ready  out  1  one-cycle pulse: if_rdata is valid
- mm_req  in  1  load/store request; held with its fields until the mm_ready cycle
- mm_we  in  1  1 = store, 0 = load
- mm_mode  in  2  word/half/byte encoding, same as the MemMode control field
- mm_addr  in  32  data address
- mm_wdata  in  32  store data
- mm_rdata  out  32  load data; held stable until the next MM capture
- mm_ready  out  1  one-cycle pulse: the load/store is done
- stall_if  out  1  combinational: if_req & ~if_ready
- stall_mm  out  1  combinational: mm_req & ~mm_ready
- mem_en  out  1  memory command strobe; exactly one cycle per access
- mem_we  out  1  write enable, qualified by mem_en
- mem_mode  out  2  access width, qualified by mem_en
- mem_addr  out  32  access address, qualified by mem_en
- mem_wdata  out  32  store data, qualified by mem_en
- mem_rdata  in  32  read data, valid in cycle E+MEM_LATENCY, where E is the mem_en cycle

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, grant=NONE, counter=0.
  - All registered outputs are 0: mem_en, mem_we, mem_mode, mem_addr, mem_wdata, if_rdata, mm_rdata, if_ready, mm_ready.
  - A reset mid-access abandons the access; no ready pulse follows.
- States: IDLE, ISSUE, WAIT, DONE. The grant register (NONE/IF/MM) is loaded on the transition into ISSUE.
- Arbitration in IDLE:
  - mm_req=1 -> grant MM, go to ISSUE (mm_req takes priority even when if_req=1).
  - Otherwise if_req=1 and if_flush=0 -> grant IF, go to ISSUE.
  - Otherwise stay in IDLE.
- Command registers: the command is registered on the IDLE->ISSUE or DONE->ISSUE transition, so mem_en=1 during ISSUE only.
  - For IF grants: mem_we=0, mem_mode=word.
  - Outside ISSUE, mem_en=0 and the other mem_* outputs hold their last values.
- ISSUE transitions:
  - Read (IF, or MM with mm_we=0): counter<=MEM_LATENCY-1, go to WAIT.
  - Write: go directly to DONE; memory completes the write at the end of ISSUE.
- WAIT:
  - counter!=0: decrement.
  - counter==0 (this is cycle E+MEM_LATENCY): capture mem_rdata into if_rdata or mm_rdata according to grant, go to DONE.
- DONE: assert the granted stage's ready for exactly this cycle, then arbitrate again:
  - The just-served requester is excluded this cycle, because its req is still high for the completed request.
  - If the other requester is pending (IF: if_req & ~if_flush), grant it and go to ISSUE; otherwise go to IDLE.
- Latency from the request-seen cycle t in IDLE:
  - Read: mem_en at t+1, ready at t+2+MEM_LATENCY.
  - Write: ready at t+2.
  - Same requester back-to-back: at least one IDLE cycle between its ready and its next ISSUE.
- Flush:
  - if_flush=1 while an IF access is in ISSUE or WAIT: the memory access still completes and the counter still runs, but a sticky discard flag is set.
  - In DONE with the discard flag set: if_ready stays 0 and if_rdata is not updated; the flag is cleared on leaving DONE.
  - if_flush=1 in IDLE or DONE suppresses an IF grant that cycle.
  - if_flush has no effect on MM accesses.
- Simultaneous requests: MM is always served first. IF then gets the port in MM's DONE cycle, so IF cannot be starved by one MM access.
- mm_req dropping mid-access: forbidden by protocol. The arbiter still completes the access and pulses mm_ready.
- Ready exclusivity: if_ready and mm_ready are never both 1, and mem_en is never 1 in two consecutive cycles.
- Width rule: mem_mode and mm_mode pass through unchanged. Byte/half lane alignment belongs to the memory, not to this block.

Test Plan:
- Reset then single fetch (MEM_LATENCY=2): if_req=1, if_addr=0x00400000 at cycle 0; mem_rdata=0x2408000A at cycle 3.
  -> mem_en=1 at cycle 1 with mem_addr=0x00400000 and mem_we=0; if_ready=1 at cycle 4 with if_rdata=0x2408000A; stall_if=1 in cycles 0-3.
- Contention: if_req and mm_req (load, 0x10010004) both rise at cycle 0.
  -> MM issued at cycle 1 and mm_ready at cycle 4; IF issued at cycle 5 (in MM's DONE) and if_ready at cycle 8; stall_if=1 through cycle 7.
- Store: mm_req=1, mm_we=1, mm_mode=byte, mm_addr=0x10010003, mm_wdata=0xFF at cycle 0.
  -> mem_en/mem_we=1 with those values at cycle 1; mm_ready=1 at cycle 2; no mm_rdata update.
- Flush mid-fetch: if_req at cycle 0, if_flush=1 at cycle 2.
  -> mem_en still pulses at cycle 1; no if_ready pulse; if_rdata keeps its prior value; state returns to IDLE at cycle 5.
- Reset mid-access: rst_n=0 during WAIT of a load.
  -> all outputs 0 the next cycle and state IDLE; no mm_ready pulse; a new load after reset completes normally.
- MEM_LATENCY=1 regression: back-to-back IF reads.
  -> ready pulses 4 cycles apart (ISSUE, WAIT, DONE, IDLE); if_ready and mm_ready are never both 1; mem_en is never high in two consecutive cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch (IF)
// and load/store (MM); MM has fixed priority, every access is strictly sequenced.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mm_req,
  input  logic        mm_we,
  input  logic [1:0]  mm_mode,
  input  logic [31:0] mm_addr,
  input  logic [31:0] mm_wdata,
  output logic [31:0] mm_rdata,
  output logic        mm_ready,
  output logic        stall_if,
  output logic        stall_mm,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_mode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned CNT_W  = 4;
  localparam logic [MODE_W-1:0] MODE_WORD = MODE_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_MM
  } grant_e;

  state_e              state_q, state_d;
  grant_e              grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                discard_q, discard_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [MODE_W-1:0]   mem_mode_q, mem_mode_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mm_rdata_q, mm_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                mm_ready_q, mm_ready_d;

  logic                if_pend;
  logic                issue_mm;
  logic                issue_if;
  logic                if_flush_hit;

  assign if_pend      = if_req & ~if_flush;
  assign if_flush_hit = (grant_q == GNT_IF) & if_flush;

  // Next-state, command and capture logic
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_mode_d  = mem_mode_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    mm_rdata_d  = mm_rdata_q;
    if_ready_d  = 1'b0;
    mm_ready_d  = 1'b0;
    issue_mm    = 1'b0;
    issue_if    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mm_req) begin
          issue_mm = 1'b1;
        end else if (if_pend) begin
          issue_if = 1'b1;
        end
      end

      ST_ISSUE: begin
        if (if_flush_hit) begin
          discard_d = 1'b1;
        end
        // Stores finish inside the ISSUE cycle; reads wait out the latency
        if ((grant_q == GNT_MM) && mem_we_q) begin
          state_d    = ST_DONE;
          mm_ready_d = 1'b1;
        end else begin
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (if_flush_hit) begin
          discard_d = 1'b1;
        end
        if (cnt_q != CNT_W'(0)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_DONE;
          if (grant_q == GNT_MM) begin
            mm_rdata_d = mem_rdata;
            mm_ready_d = 1'b1;
          end else if (!(discard_q || if_flush_hit)) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        // The stage just served still holds req for the finished access
        discard_d = 1'b0;
        if ((grant_q == GNT_IF) && mm_req) begin
          issue_mm = 1'b1;
        end else if ((grant_q == GNT_MM) && if_pend) begin
          issue_if = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (issue_mm) begin
      state_d     = ST_ISSUE;
      grant_d     = GNT_MM;
      mem_en_d    = 1'b1;
      mem_we_d    = mm_we;
      mem_mode_d  = mm_mode;
      mem_addr_d  = mm_addr;
      mem_wdata_d = mm_wdata;
    end else if (issue_if) begin
      state_d    = ST_ISSUE;
      grant_d    = GNT_IF;
      mem_en_d   = 1'b1;
      mem_we_d   = 1'b0;
      mem_mode_d = MODE_WORD;
      mem_addr_d = if_addr;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_NONE;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_mode_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      mm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      mm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_mode_q  <= mem_mode_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mm_rdata_q  <= mm_rdata_d;
      if_ready_q  <= if_ready_d;
      mm_ready_q  <= mm_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_mode  = mem_mode_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mm_rdata  = mm_rdata_q;
  assign if_ready  = if_ready_q;
  assign mm_ready  = mm_ready_q;

  // Hazard-unit stalls follow the live request
  assign stall_if = if_req & ~if_ready_q;
  assign stall_mm = mm_req & ~mm_ready_q;

endmodule
